conv3x3_stream_mc: RTL and testbench

Parametrised streaming 3x3 convolution engine; successor to the single-channel conv_3x3 used in the first-layer stream path.
- Accepts one raster-order pixel per handshake and keeps two line buffers plus a 3x3 window.
- Computes NUM_OC output channels in parallel with signed weights, valid-mode (no padding).
- Full ready/valid backpressure on both sides, and per-frame width/height.

---
 rtl/conv3x3_stream_mc_pkg.sv | 25 ++
 rtl/conv3x3_stream_mc_if.sv | 29 ++
 rtl/conv3x3_stream_mc_mac.sv | 57 +++++
 rtl/conv3x3_stream_mc.sv | 209 ++++++++++++++++++++
 tb/tb_conv3x3_stream_mc.sv | 341 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/conv3x3_stream_mc_pkg.sv
// Shared constants, FSM encoding and width helpers for the multi-channel 3x3 stream convolution.
package conv_pkg;

   localparam int unsigned TAPS = 9;

   typedef enum logic [1:0] {
      StIdle  = 2'd0,
      StRun   = 2'd1,
      StDrain = 2'd2
   } conv_state_e;

   // Never returns less than 1 so single-entry selects still get a legal 1-bit port.
   function automatic int unsigned clog2(input int unsigned n);
      int unsigned r;
      r = 1;
      while ((32'd1 << r) < n) r++;
      return r;
   endfunction

   // Nine products of (PIX_W+1)-bit signed by WT_W-bit signed need 4 more bits of headroom.
   function automatic int unsigned acc_width(input int unsigned pix_w, input int unsigned wt_w);
      return pix_w + wt_w + 5;
   endfunction

endpackage

// File: rtl/conv3x3_stream_mc_if.sv
// Pixel-in / result-out ready-valid streams of the 3x3 convolution engine.
interface conv3x3_stream_mc_if
   import conv_pkg::*;
#(
   parameter int unsigned PIX_W  = 8,
   parameter int unsigned WT_W   = 8,
   parameter int unsigned NUM_OC = 4,
   parameter int unsigned ACC_W  = acc_width(PIX_W, WT_W)
);

   logic                    in_valid;
   logic                    in_ready;
   logic [PIX_W-1:0]        in_pixel;
   logic                    out_valid;
   logic                    out_ready;
   logic [NUM_OC*ACC_W-1:0] out_pixel;
   logic                    out_last;

   modport master (
      output in_valid, in_pixel, out_ready,
      input  in_ready, out_valid, out_pixel, out_last
   );

   modport slave (
      input  in_valid, in_pixel, out_ready,
      output in_ready, out_valid, out_pixel, out_last
   );

endinterface

// File: rtl/conv3x3_stream_mc_mac.sv
// One output channel: nine signed products (stage 1) summed into the result register (stage 2).
// CONV3X3_RELU_EN clamps negative sums to zero in stage 2.
module conv3x3_mac
   import conv_pkg::*;
#(
   parameter int unsigned PIX_W = 8,
   parameter int unsigned WT_W  = 8,
   parameter int unsigned ACC_W = acc_width(PIX_W, WT_W)
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    ld1,
   input  logic                    ld2,
   input  logic [TAPS*PIX_W-1:0]   taps,
   input  logic [TAPS*WT_W-1:0]    wts,
   output logic signed [ACC_W-1:0] result
);

   localparam int unsigned PRD_W = PIX_W + WT_W + 1;

   logic signed [PRD_W-1:0] prod_d [TAPS];
   logic signed [PRD_W-1:0] prod_q [TAPS];
   logic signed [ACC_W-1:0] sum;
   logic signed [ACC_W-1:0] result_d;

   // Pixels are unsigned: prepend a zero so the signed multiply treats them as positive.
   always_comb begin
      for (int t = 0; t < TAPS; t++) begin
         prod_d[t] = PRD_W'($signed({1'b0, taps[t*PIX_W +: PIX_W]}))
                   * PRD_W'($signed(wts[t*WT_W +: WT_W]));
      end
   end

   always_comb begin
      sum = '0;
      for (int t = 0; t < TAPS; t++) begin
         sum = sum + ACC_W'(prod_q[t]);
      end
      result_d = sum;
`ifdef CONV3X3_RELU_EN
      if (sum[ACC_W-1]) result_d = '0;
`endif
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int t = 0; t < TAPS; t++) prod_q[t] <= '0;
         result <= '0;
      end else begin
         if (ld1) begin
            for (int t = 0; t < TAPS; t++) prod_q[t] <= prod_d[t];
         end
         if (ld2) result <= result_d;
      end
   end

endmodule

// File: rtl/conv3x3_stream_mc.sv
// Streaming valid-mode 3x3 convolution, NUM_OC channels in parallel, ready/valid on both sides.
// Optional macro CONV3X3_RELU_EN clamps every channel result at zero.
module conv3x3_stream_mc
   import conv_pkg::*;
#(
   parameter int unsigned PIX_W  = 8,
   parameter int unsigned WT_W   = 8,
   parameter int unsigned NUM_OC = 4,
   parameter int unsigned MAX_W  = 64,
   parameter int unsigned ACC_W  = acc_width(PIX_W, WT_W)
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [15:0]                img_width,
   input  logic [15:0]                img_height,
   input  logic                       wt_we,
   input  logic [clog2(NUM_OC)-1:0]   wt_ch,
   input  logic [3:0]                 wt_idx,
   input  logic signed [WT_W-1:0]     wt_data,
   output logic                       busy,
   conv3x3_stream_mc_if.slave         strm
);

   localparam int unsigned XW = clog2(MAX_W);

   conv_state_e state_q, state_d;
   logic [15:0] x_q, x_d, y_q, y_d, w_q, w_d, h_q, h_d;
   logic [15:0] cur_x, cur_y, cur_w, cur_h;
   logic [XW-1:0] xi;

   logic signed [WT_W-1:0] wt_q [NUM_OC][TAPS];
   logic [PIX_W-1:0] lb_a [MAX_W];  // row y-1
   logic [PIX_W-1:0] lb_b [MAX_W];  // row y-2
   logic [PIX_W-1:0] win_q [3][2];  // columns x-2, x-1 for rows y-2..y
   logic [PIX_W-1:0] col [3];
   logic [TAPS*PIX_W-1:0] taps;

   logic en, accept, emit, last_px;
   logic v1_q, last1_q;
   logic out_valid_q, out_last_q;
   logic ld1, ld2;
   logic signed [ACC_W-1:0] ch_res [NUM_OC];
   logic [NUM_OC*ACC_W-1:0] out_pix;

   // A held output freezes every stage, including input acceptance.
   assign en            = !(out_valid_q && !strm.out_ready);
   assign strm.in_ready = (state_q != StDrain) && en;
   assign accept        = strm.in_valid && strm.in_ready;
   assign busy          = (state_q != StIdle);

   // The first pixel of a frame sits at (0,0) and is measured against the incoming geometry.
   always_comb begin
      cur_x = (state_q == StIdle) ? 16'd0 : x_q;
      cur_y = (state_q == StIdle) ? 16'd0 : y_q;
      cur_w = (state_q == StIdle) ? img_width : w_q;
      cur_h = (state_q == StIdle) ? img_height : h_q;
   end

   assign xi      = cur_x[XW-1:0];
   assign emit    = accept && (cur_x >= 16'd2) && (cur_y >= 16'd2);
   assign last_px = (cur_x == cur_w - 16'd1) && (cur_y == cur_h - 16'd1);

   always_comb begin
      state_d = state_q;
      x_d     = x_q;
      y_d     = y_q;
      w_d     = w_q;
      h_d     = h_q;
      case (state_q)
         StIdle: begin
            if (accept) begin
               w_d     = img_width;
               h_d     = img_height;
               x_d     = 16'd1;
               y_d     = 16'd0;
               state_d = StRun;
            end
         end
         StRun: begin
            if (accept) begin
               if (x_q == w_q - 16'd1) begin
                  x_d = 16'd0;
                  y_d = y_q + 16'd1;
                  if (y_q == h_q - 16'd1) state_d = StDrain;
               end else begin
                  x_d = x_q + 16'd1;
               end
            end
         end
         StDrain: begin
            if (out_valid_q && strm.out_ready && out_last_q) state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= StIdle;
         x_q     <= '0;
         y_q     <= '0;
         w_q     <= '0;
         h_q     <= '0;
      end else begin
         state_q <= state_d;
         x_q     <= x_d;
         y_q     <= y_d;
         w_q     <= w_d;
         h_q     <= h_d;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int c = 0; c < NUM_OC; c++) begin
            for (int t = 0; t < TAPS; t++) wt_q[c][t] <= '0;
         end
      end else if (wt_we && (state_q == StIdle) && (wt_idx < 4'd9)
                   && (32'(wt_ch) < NUM_OC)) begin
         wt_q[wt_ch][wt_idx] <= wt_data;
      end
   end

   always_ff @(posedge clk) begin
      if (accept) begin
         lb_b[xi] <= lb_a[xi];
         lb_a[xi] <= strm.in_pixel;
      end
   end

   always_comb begin
      col[0] = lb_b[xi];
      col[1] = lb_a[xi];
      col[2] = strm.in_pixel;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int r = 0; r < 3; r++) begin
            win_q[r][0] <= '0;
            win_q[r][1] <= '0;
         end
      end else if (accept) begin
         for (int r = 0; r < 3; r++) begin
            win_q[r][0] <= win_q[r][1];
            win_q[r][1] <= col[r];
         end
      end
   end

   // Tap order is row-major: k00 (row y-2, column x-2) first, k22 (current pixel) last.
   always_comb begin
      taps = '0;
      for (int r = 0; r < 3; r++) begin
         taps[(r*3)*PIX_W +: PIX_W]   = win_q[r][0];
         taps[(r*3+1)*PIX_W +: PIX_W] = win_q[r][1];
         taps[(r*3+2)*PIX_W +: PIX_W] = col[r];
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         v1_q        <= 1'b0;
         last1_q     <= 1'b0;
         out_valid_q <= 1'b0;
         out_last_q  <= 1'b0;
      end else if (en) begin
         v1_q        <= emit;
         last1_q     <= emit && last_px;
         out_valid_q <= v1_q;
         out_last_q  <= v1_q && last1_q;
      end
   end

   assign ld1 = emit;
   assign ld2 = en && v1_q;

   for (genvar c = 0; c < NUM_OC; c++) begin : g_ch
      logic [TAPS*WT_W-1:0] wts;

      always_comb begin
         for (int t = 0; t < TAPS; t++) wts[t*WT_W +: WT_W] = wt_q[c][t];
      end

      conv3x3_mac #(
         .PIX_W (PIX_W),
         .WT_W  (WT_W),
         .ACC_W (ACC_W)
      ) u_mac (
         .clk    (clk),
         .rst    (rst),
         .ld1    (ld1),
         .ld2    (ld2),
         .taps   (taps),
         .wts    (wts),
         .result (ch_res[c])
      );
   end

   always_comb begin
      out_pix = '0;
      for (int c = 0; c < NUM_OC; c++) out_pix[c*ACC_W +: ACC_W] = ch_res[c];
   end

   assign strm.out_pixel = out_pix;
   assign strm.out_valid = out_valid_q;
   assign strm.out_last  = out_last_q;

endmodule

// File: tb/tb_conv3x3_stream_mc.sv
// Self-checking bench for conv3x3_stream_mc against a direct-convolution reference model.
module tb_conv3x3_stream_mc;
   import conv_pkg::*;

   localparam int PIX_W  = 8;
   localparam int WT_W   = 8;
   localparam int NUM_OC = 4;
   localparam int MAX_W  = 64;
   localparam int ACC_W  = PIX_W + WT_W + 5;
   localparam int OW     = NUM_OC * ACC_W;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic [15:0]       img_width = '0;
   logic [15:0]       img_height = '0;
   logic              wt_we = 1'b0;
   logic [1:0]        wt_ch = '0;
   logic [3:0]        wt_idx = '0;
   logic signed [7:0] wt_data = '0;
   logic              busy;

   conv3x3_stream_mc_if #(.PIX_W(PIX_W), .WT_W(WT_W), .NUM_OC(NUM_OC), .ACC_W(ACC_W)) bus ();

   conv3x3_stream_mc #(
      .PIX_W  (PIX_W),
      .WT_W   (WT_W),
      .NUM_OC (NUM_OC),
      .MAX_W  (MAX_W),
      .ACC_W  (ACC_W)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .img_width  (img_width),
      .img_height (img_height),
      .wt_we      (wt_we),
      .wt_ch      (wt_ch),
      .wt_idx     (wt_idx),
      .wt_data    (wt_data),
      .busy       (busy),
      .strm       (bus)
   );

   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;
   int pix[$];
   int mw[NUM_OC][9];
   logic [OW-1:0] got_pix[$];
   logic          got_last[$];
   int stall_bad, stall_cycles;

   // Reference: output i of a w-wide frame is the dot product of the 3x3 patch ending at it.
   function automatic logic [OW-1:0] exp_vec(input int w, input int i);
      logic [OW-1:0] v;
      longint s;
      int ox, oy;
      ox = i % (w - 2) + 2;
      oy = i / (w - 2) + 2;
      v = '0;
      for (int c = 0; c < NUM_OC; c++) begin
         s = 0;
         for (int r = 0; r < 3; r++)
            for (int k = 0; k < 3; k++)
               s += longint'(pix[(oy - 2 + r) * w + ox - 2 + k]) * longint'(mw[c][r * 3 + k]);
`ifdef CONV3X3_RELU_EN
         if (s < 0) s = 0;
`endif
         v[c*ACC_W +: ACC_W] = s[ACC_W-1:0];
      end
      return v;
   endfunction

   function automatic int ch_of(input logic [OW-1:0] v, input int c);
      logic [ACC_W-1:0] s;
      s = v[c*ACC_W +: ACC_W];
      return int'($signed(s));
   endfunction

   task automatic load_wt(input int c, input int t, input int val);
      wt_we = 1'b1; wt_ch = 2'(c); wt_idx = 4'(t); wt_data = 8'(val);
      @(posedge clk); #1;
      wt_we = 1'b0;
      mw[c][t] = val;
   endtask

   task automatic load_ramp_weights();
      for (int t = 0; t < 9; t++) begin
         load_wt(0, t, t + 1);
         load_wt(1, t, t - 4);
         load_wt(2, t, -3 * t - 1);
         load_wt(3, t, 9 - 2 * t);
      end
   endtask

   task automatic set_ramp(input int n);
      pix.delete();
      for (int i = 0; i < n; i++) pix.push_back(i + 1);
   endtask

   task automatic set_random(input int n);
      pix.delete();
      for (int i = 0; i < n; i++) pix.push_back(int'($urandom_range(0, 255)));
   endtask

   // Drives one frame cycle by cycle; handshakes are sampled on the falling edge.
   task automatic run_frame(input int w, input int h, input int stall_at, input bit gaps,
                            input bit rnd_ready, input int poke_at, input int stop_after);
      int n, exp_n, idx, cyc, gap_left, stall_left;
      bit poked, stalled;
      logic [OW-1:0] held;
      n = w * h; exp_n = (w - 2) * (h - 2);
      idx = 0; cyc = 0; gap_left = 0; stall_left = 0; poked = 0; stalled = 0; held = '0;
      got_pix.delete(); got_last.delete(); stall_bad = 0; stall_cycles = 0;
      img_width = 16'(w); img_height = 16'(h);
      while ((idx < n || got_pix.size() < exp_n) && cyc < 4000
             && !(stop_after >= 0 && idx >= stop_after)) begin
         if (stall_at >= 0 && !stalled && got_pix.size() == stall_at && bus.out_valid) begin
            stalled = 1; stall_left = 5; held = bus.out_pixel;
         end
         bus.out_ready = (stall_left == 0) && (!rnd_ready || $urandom_range(0, 3) != 0);
         bus.in_valid  = (idx < n) && (gap_left == 0);
         bus.in_pixel  = '0;
         if (idx < n) bus.in_pixel = PIX_W'(pix[idx]);
         wt_we = 1'b0;
         if (poke_at >= 0 && !poked && idx == poke_at) begin
            poked = 1; wt_we = 1'b1; wt_ch = 2'd0; wt_idx = 4'd0; wt_data = 8'sd100;
         end
         @(negedge clk);
         if (stall_left > 0) begin
            stall_cycles++;
            if (bus.in_ready || !bus.out_valid || bus.out_pixel !== held) stall_bad++;
            stall_left--;
         end
         if (bus.out_valid && bus.out_ready) begin
            got_pix.push_back(bus.out_pixel);
            got_last.push_back(bus.out_last);
         end
         if (bus.in_valid && bus.in_ready) begin
            idx++;
            if (gaps && idx % 4 == 0) gap_left = 3;
         end else if (gap_left > 0) begin
            gap_left--;
         end
         @(posedge clk); #1;
         cyc++;
      end
      bus.in_valid = 1'b0; bus.out_ready = 1'b1; wt_we = 1'b0;
      checks++;
      if (cyc >= 4000) begin
         errors++;
         $display("FAIL frame_timeout: got %0d of %0d outputs, required completion", got_pix.size(),
                  exp_n);
      end
   endtask

   task automatic test_reset();
      checks += 5;
      if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid: got %b want 0", bus.out_valid); end
      if (bus.out_last !== 1'b0) begin errors++; $display("FAIL rst_out_last: got %b want 0", bus.out_last); end
      if (bus.out_pixel !== '0) begin errors++; $display("FAIL rst_out_pixel: got %h want 0", bus.out_pixel); end
      if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b want 0", busy); end
      if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL rst_in_ready: got %b want 1", bus.in_ready); end
   endtask

   task automatic test_ramp();
      int ref0[6] = '{537, 582, 627, 672, 717, 852};
      set_ramp(49);
      load_ramp_weights();
      run_frame(7, 7, -1, 0, 0, -1, -1);
      checks++;
      if (got_pix.size() != 25) begin errors++; $display("FAIL ramp_count: got %0d want 25", got_pix.size()); end
      for (int i = 0; i < got_pix.size(); i++) begin
         checks += 2;
         if (got_pix[i] !== exp_vec(7, i)) begin errors++; $display("FAIL ramp_out[%0d]: got %h want %h", i, got_pix[i], exp_vec(7, i)); end
         if (got_last[i] !== (i == 24)) begin errors++; $display("FAIL ramp_last[%0d]: got %b want %b", i, got_last[i], i == 24); end
         if (i < 6) begin
            checks++;
            if (ch_of(got_pix[i], 0) != ref0[i]) begin errors++; $display("FAIL ramp_ch0[%0d]: got %0d want %0d", i, ch_of(got_pix[i], 0), ref0[i]); end
         end
         if (i == 24) begin
            checks++;
            if (ch_of(got_pix[i], 0) != 1977) begin errors++; $display("FAIL ramp_ch0_last: got %0d want 1977", ch_of(got_pix[i], 0)); end
         end
      end
   endtask

   task automatic test_const_neg();
      int want;
`ifdef CONV3X3_RELU_EN
      want = 0;
`else
      want = -2295;
`endif
      pix.delete();
      for (int i = 0; i < 25; i++) pix.push_back(255);
      for (int t = 0; t < 9; t++) load_wt(1, t, -1);
      run_frame(5, 5, -1, 0, 0, -1, -1);
      checks++;
      if (got_pix.size() != 9) begin errors++; $display("FAIL neg_count: got %0d want 9", got_pix.size()); end
      for (int i = 0; i < got_pix.size(); i++) begin
         checks += 3;
         if (ch_of(got_pix[i], 1) != want) begin errors++; $display("FAIL neg_ch1[%0d]: got %0d want %0d", i, ch_of(got_pix[i], 1), want); end
         if (got_pix[i] !== exp_vec(5, i)) begin errors++; $display("FAIL neg_out[%0d]: got %h want %h", i, got_pix[i], exp_vec(5, i)); end
         if (got_last[i] !== (i == 8)) begin errors++; $display("FAIL neg_last[%0d]: got %b want %b", i, got_last[i], i == 8); end
      end
   endtask

   task automatic test_stall();
      set_ramp(49);
      load_ramp_weights();
      run_frame(7, 7, 2, 0, 0, -1, -1);
      checks += 3;
      if (got_pix.size() != 25) begin errors++; $display("FAIL stall_count: got %0d want 25", got_pix.size()); end
      if (stall_cycles != 5) begin errors++; $display("FAIL stall_len: got %0d want 5", stall_cycles); end
      if (stall_bad != 0) begin errors++; $display("FAIL stall_hold: got %0d bad cycles want 0", stall_bad); end
      for (int i = 0; i < got_pix.size(); i++) begin
         checks += 2;
         if (got_pix[i] !== exp_vec(7, i)) begin errors++; $display("FAIL stall_out[%0d]: got %h want %h", i, got_pix[i], exp_vec(7, i)); end
         if (got_last[i] !== (i == 24)) begin errors++; $display("FAIL stall_last[%0d]: got %b want %b", i, got_last[i], i == 24); end
      end
   endtask

   task automatic test_gaps();
      set_ramp(49);
      run_frame(7, 7, -1, 1, 0, -1, -1);
      checks++;
      if (got_pix.size() != 25) begin errors++; $display("FAIL gaps_count: got %0d want 25", got_pix.size()); end
      for (int i = 0; i < got_pix.size(); i++) begin
         checks += 2;
         if (got_pix[i] !== exp_vec(7, i)) begin errors++; $display("FAIL gaps_out[%0d]: got %h want %h", i, got_pix[i], exp_vec(7, i)); end
         if (got_last[i] !== (i == 24)) begin errors++; $display("FAIL gaps_last[%0d]: got %b want %b", i, got_last[i], i == 24); end
      end
   endtask

   task automatic test_mid_reset();
      set_ramp(49);
      run_frame(7, 7, -1, 0, 0, -1, 20);
      checks++;
      if (busy !== 1'b1) begin errors++; $display("FAIL midrst_busy_before: got %b want 1", busy); end
      rst = 1'b1;
      #1;
      checks += 2;
      if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL midrst_out_valid: got %b want 0", bus.out_valid); end
      if (busy !== 1'b0) begin errors++; $display("FAIL midrst_busy: got %b want 0", busy); end
      @(posedge clk); #1;
      rst = 1'b0;
      for (int c = 0; c < NUM_OC; c++) for (int t = 0; t < 9; t++) mw[c][t] = 0;
      // Weights were cleared, so a frame before reloading must produce all-zero results.
      run_frame(7, 7, -1, 0, 0, -1, -1);
      for (int i = 0; i < got_pix.size(); i++) begin
         checks++;
         if (got_pix[i] !== exp_vec(7, i)) begin errors++; $display("FAIL midrst_zero[%0d]: got %h want %h", i, got_pix[i], exp_vec(7, i)); end
      end
      load_ramp_weights();
      run_frame(7, 7, -1, 0, 0, -1, -1);
      checks += 3;
      if (got_pix.size() != 25) begin errors++; $display("FAIL midrst_count: got %0d want 25", got_pix.size()); end
      else begin
         if (ch_of(got_pix[0], 0) != 537) begin errors++; $display("FAIL midrst_first: got %0d want 537", ch_of(got_pix[0], 0)); end
         if (ch_of(got_pix[24], 0) != 1977) begin errors++; $display("FAIL midrst_last: got %0d want 1977", ch_of(got_pix[24], 0)); end
      end
      for (int i = 0; i < got_pix.size(); i++) begin
         checks++;
         if (got_pix[i] !== exp_vec(7, i)) begin errors++; $display("FAIL midrst_out[%0d]: got %h want %h", i, got_pix[i], exp_vec(7, i)); end
      end
   endtask

   task automatic test_wt_ignore();
      set_ramp(49);
      run_frame(7, 7, -1, 0, 0, 10, -1);
      checks += 2;
      if (got_pix.size() != 25) begin errors++; $display("FAIL wtign_count: got %0d want 25", got_pix.size()); end
      else if (ch_of(got_pix[0], 0) != 537) begin errors++; $display("FAIL wtign_first: got %0d want 537", ch_of(got_pix[0], 0)); end
      for (int i = 0; i < got_pix.size(); i++) begin
         if (got_pix[i] !== exp_vec(7, i)) begin errors++; $display("FAIL wtign_out[%0d]: got %h want %h", i, got_pix[i], exp_vec(7, i)); end
      end
   endtask

   task automatic test_back_to_back();
      set_random(9);
      run_frame(3, 3, -1, 0, 0, -1, -1);
      checks += 2;
      if (got_pix.size() != 1) begin errors++; $display("FAIL b2b3_count: got %0d want 1", got_pix.size()); end
      else begin
         if (got_last[0] !== 1'b1) begin errors++; $display("FAIL b2b3_last: got %b want 1", got_last[0]); end
         if (got_pix[0] !== exp_vec(3, 0)) begin errors++; $display("FAIL b2b3_out: got %h want %h", got_pix[0], exp_vec(3, 0)); end
      end
      set_random(16);
      run_frame(4, 4, -1, 0, 0, -1, -1);
      checks += 2;
      if (got_pix.size() != 4) begin errors++; $display("FAIL b2b4_count: got %0d want 4", got_pix.size()); end
      if (busy !== 1'b0) begin errors++; $display("FAIL b2b4_busy: got %b want 0", busy); end
      for (int i = 0; i < got_pix.size(); i++) begin
         checks += 2;
         if (got_pix[i] !== exp_vec(4, i)) begin errors++; $display("FAIL b2b4_out[%0d]: got %h want %h", i, got_pix[i], exp_vec(4, i)); end
         if (got_last[i] !== (i == 3)) begin errors++; $display("FAIL b2b4_last[%0d]: got %b want %b", i, got_last[i], i == 3); end
      end
   endtask

   task automatic test_random();
      int w, h;
      for (int k = 0; k < 3; k++) begin
         w = int'($urandom_range(3, 10));
         h = int'($urandom_range(3, 8));
         for (int c = 0; c < NUM_OC; c++)
            for (int t = 0; t < 9; t++) load_wt(c, t, int'($urandom_range(0, 255)) - 128);
         set_random(w * h);
         run_frame(w, h, -1, k[0], 1, -1, -1);
         checks++;
         if (got_pix.size() != (w - 2) * (h - 2)) begin errors++; $display("FAIL rnd_count: got %0d want %0d", got_pix.size(), (w - 2) * (h - 2)); end
         for (int i = 0; i < got_pix.size(); i++) begin
            checks += 2;
            if (got_pix[i] !== exp_vec(w, i)) begin errors++; $display("FAIL rnd_out[%0d]: got %h want %h", i, got_pix[i], exp_vec(w, i)); end
            if (got_last[i] !== (i == (w - 2) * (h - 2) - 1)) begin errors++; $display("FAIL rnd_last[%0d]: got %b", i, got_last[i]); end
         end
      end
   endtask

   initial begin
      bus.in_valid = 1'b0;
      bus.in_pixel = '0;
      bus.out_ready = 1'b1;
      for (int c = 0; c < NUM_OC; c++) for (int t = 0; t < 9; t++) mw[c][t] = 0;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      test_reset();
      test_ramp();
      test_const_neg();
      test_stall();
      test_gaps();
      test_mid_reset();
      test_wt_ignore();
      test_back_to_back();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
